// File: rtl/add16_rr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// add16_rr_sequencer_pkg
//   Shared definitions for the round-robin add16 sequencer:
//   - W        : datapath word width, fixed by the 16-bit adder
//   - state_t  : sequencer FSM encoding (IDLE / BURST)
//   - idw_of() : width of a requester index, clog2(n) with a floor of 1
// ---------------------------------------------------------------------------
package add16_rr_sequencer_pkg;

    localparam int W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Index width for n requesters (supports n up to 256, floor of 1 bit).
    function automatic int idw_of(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 8; k++) begin
            if ((1 << k) < n) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/add16_rr_sequencer_if.sv
// ---------------------------------------------------------------------------
// add16_rr_sequencer_if
//   Bundles the requester-side and result-side signals of the sequencer.
//   Ports (from the sequencer's point of view, modport slave):
//     req_valid  in   NREQ      per-requester word valid
//     req_ready  out  NREQ      per-requester accept strobe (one-hot or zero)
//     req_a      in   NREQ*W    operand A, requester i at [i*W +: W]
//     req_b      in   NREQ*W    operand B, same packing
//     req_cin    in   NREQ      carry-in, used on the first word of a burst only
//     req_last   in   NREQ      final (most-significant) word of a burst
//     rsp_valid  out  1         result slot holds a word
//     rsp_ready  in   1         consumer takes the result
//     rsp_id     out  IDW       requester that produced the result
//     rsp_sum    out  W         sum word
//     rsp_cout   out  1         carry-out of this word
//     rsp_last   out  1         copy of req_last for this word
//     dbg_state  out  state_t   FSM state, for observation only
//     dbg_rr_ptr out  IDW       round-robin pointer, for observation only
//
//   Handshake: a transfer happens on a rising clock edge where valid and
//   ready are both high. A producer holds valid and its payload stable until
//   the transfer; ready may come and go freely and never depends on the
//   producer changing its payload. On the request side the sequencer raises
//   at most one req_ready bit per cycle.
// ---------------------------------------------------------------------------
interface add16_rr_sequencer_if
    import add16_rr_sequencer_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = idw_of(NREQ)
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_last;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_last;

    state_t            dbg_state;
    logic [IDW-1:0]    dbg_rr_ptr;

    // Client / environment side.
    modport master (
        output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last,
        input  dbg_state, dbg_rr_ptr
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last,
        output dbg_state, dbg_rr_ptr
    );

endinterface

// File: rtl/add16_rr_sequencer_fulladd16.sv
// ---------------------------------------------------------------------------
// fulladd16
//   16-bit ripple-style full adder (synthesis picks the carry structure).
//   Ports:
//     s      out  16  sum, modulo 2^16
//     c_out  out  1   carry-out
//     a      in   16  operand A
//     b      in   16  operand B
//     c_in   in   1   carry-in
// ---------------------------------------------------------------------------
module fulladd16 (
    output logic [15:0] s,
    output logic        c_out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in
);

    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {16'b0, c_in};

endmodule

// File: rtl/add16_rr_sequencer.sv
// ---------------------------------------------------------------------------
// add16_rr_sequencer
//   Shares one fulladd16 between NREQ requesters with round-robin arbitration.
//   A requester sends a burst of words, least-significant first; the carry
//   chains from word to word so a burst is one multi-precision add. Results
//   land in a single registered slot, one cycle after the request is taken.
//   Ports:
//     clk    in   1                         rising-edge clock
//     rst_n  in   1                         asynchronous active-low reset
//     bus    add16_rr_sequencer_if.slave    request/result bundle
// ---------------------------------------------------------------------------
module add16_rr_sequencer
    import add16_rr_sequencer_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    add16_rr_sequencer_if.slave        bus
);

    // Registered state
    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  owner_q;
    logic            carry_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [W-1:0]    rsp_sum_q;
    logic            rsp_cout_q;
    logic            rsp_last_q;

    // Combinational signals
    logic            slot_free;
    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  gnt;
    logic            valid_g;
    logic            cin_g;
    logic            last_g;
    logic [W-1:0]    a_g;
    logic [W-1:0]    b_g;
    logic            accept;
    logic            cin_sel;
    logic [IDW-1:0]  next_ptr;
    logic [NREQ-1:0] ready_c;
    logic [W-1:0]    sum;
    logic            cout;

    // A new word may enter only if the slot is empty or drains this cycle.
    assign slot_free = !rsp_valid_q || bus.rsp_ready;

    // Rotated priority pick: the lowest valid index at or above rr_ptr wins;
    // if none exists, wrap around to the lowest valid index overall. The
    // second loop overrides the first, so its hit takes precedence.
    always_comb begin
        pick_valid = |bus.req_valid;
        pick_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                pick_idx = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
                pick_idx = IDW'(i);
            end
        end
    end

    // The burst owner keeps the grant until its last word goes through.
    assign gnt = (state_q == BURST) ? owner_q : pick_idx;

    // Operand / control mux for the granted requester.
    always_comb begin
        valid_g = 1'b0;
        cin_g   = 1'b0;
        last_g  = 1'b0;
        a_g     = '0;
        b_g     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt) begin
                valid_g = bus.req_valid[i];
                cin_g   = bus.req_cin[i];
                last_g  = bus.req_last[i];
                a_g     = bus.req_a[i*W +: W];
                b_g     = bus.req_b[i*W +: W];
            end
        end
    end

    // FSM next-state and accept decision.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cin_sel = 1'b0;
        unique case (state_q)
            IDLE: begin
                cin_sel = cin_g;
                if (slot_free && pick_valid) begin
                    accept = 1'b1;
                    if (!last_g) begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                // Mid-burst words continue the chain from the previous word.
                cin_sel = carry_q;
                if (slot_free && valid_g) begin
                    accept = 1'b1;
                    if (last_g) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ready_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            ready_c[i] = accept && (IDW'(i) == gnt);
        end
    end

    assign next_ptr = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;

    fulladd16 u_add (
        .s     (sum),
        .c_out (cout),
        .a     (a_g),
        .b     (b_g),
        .c_in  (cin_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= gnt;
                rsp_sum_q   <= sum;
                rsp_cout_q  <= cout;
                rsp_last_q  <= last_g;
                carry_q     <= cout;
                owner_q     <= gnt;
                // Only a completed burst moves the pointer on.
                if (last_g) begin
                    rr_ptr_q <= next_ptr;
                end
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_last   = rsp_last_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_rr_ptr = rr_ptr_q;

endmodule
